// File: rtl/array_shift_down.sv
// ============================================================================
// Module  : array_shift_down
// Brief   : Multi-array word heap with write, read, size query and a
//           multi-cycle shiftDown that removes one word from an array.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module array_shift_down #(
  parameter int MemoryElementWidth = 12,
  parameter int NArea              = 4,
  parameter int NArrays            = 20
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [1:0]                    req_op,
  input  logic [MemoryElementWidth-1:0] req_array,
  input  logic [MemoryElementWidth-1:0] req_index,
  input  logic [MemoryElementWidth-1:0] req_data,
  output logic                          resp_valid,
  output logic [MemoryElementWidth-1:0] resp_data,
  output logic                          resp_error
);

  localparam int W     = MemoryElementWidth;
  localparam int DEPTH = NArrays * NArea;
  localparam int AW    = (DEPTH > 1)   ? $clog2(DEPTH)   : 1;
  localparam int AIW   = (NArrays > 1) ? $clog2(NArrays) : 1;
  localparam int KIW   = (NArea > 1)   ? $clog2(NArea)   : 1;

  localparam logic [KIW-1:0] LAST_K   = KIW'(NArea - 1);
  localparam logic [KIW-1:0] PEN_K    = KIW'(NArea - 2);
  localparam logic [W-1:0]   NARR_W   = W'(NArrays);
  localparam logic [W-1:0]   NAREA_W  = W'(NArea);

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_SHIFT = 2'd2;
  localparam logic [1:0] OP_SIZE  = 2'd3;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CAPTURE = 3'd1;
  localparam logic [2:0] S_MOVE    = 3'd2;
  localparam logic [2:0] S_CLEAR   = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  logic [2:0]     state_q, state_d;
  logic [AIW-1:0] array_q, array_d;
  logic [KIW-1:0] idx_q, idx_d;
  logic           err_q, err_d;
  logic [W-1:0]   resp_data_q, resp_data_d;
  logic [W-1:0]   size_q [NArrays];
  logic [W-1:0]   size_d [NArrays];
  logic [W-1:0]   heap_q [DEPTH];
  logic [W-1:0]   heap_d [DEPTH];

  logic           w_arr_bad;
  logic           w_idx_bad;
  logic           w_bad;
  logic [AIW-1:0] w_acc_a;
  logic [KIW-1:0] w_acc_k;
  logic [AW-1:0]  w_acc_addr;
  logic [W-1:0]   w_k_plus;

  function automatic logic [AW-1:0] addr_of(input logic [AIW-1:0] a, input logic [KIW-1:0] k);
    return AW'(int'(a) * NArea + int'(k));
  endfunction

  assign w_arr_bad  = (req_array >= NARR_W);
  assign w_idx_bad  = (req_index >= NAREA_W);
  assign w_bad      = w_arr_bad | ((req_op != OP_SIZE) & w_idx_bad);
  assign w_acc_a    = req_array[AIW-1:0];
  assign w_acc_k    = req_index[KIW-1:0];
  // Out-of-range fields never reach the heap address path.
  assign w_acc_addr = (w_arr_bad | w_idx_bad) ? '0 : addr_of(w_acc_a, w_acc_k);
  assign w_k_plus   = req_index + W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      array_q     <= '0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      resp_data_q <= '0;
      for (int i = 0; i < NArrays; i++) size_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      array_q     <= array_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      resp_data_q <= resp_data_d;
      size_q      <= size_d;
    end
  end

  always_ff @(posedge clock) begin
    heap_q <= heap_d;
  end

  always_comb begin
    state_d     = state_q;
    array_d     = array_q;
    idx_d       = idx_q;
    err_d       = err_q;
    resp_data_d = resp_data_q;
    size_d      = size_q;
    heap_d      = heap_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          array_d     = w_acc_a;
          idx_d       = w_acc_k;
          err_d       = w_bad;
          resp_data_d = '0;
          state_d     = S_RESP;
          if (!w_bad) begin
            case (req_op)
              OP_WRITE: begin
                heap_d[w_acc_addr] = req_data;
                if (size_q[w_acc_a] < w_k_plus) size_d[w_acc_a] = w_k_plus;
                resp_data_d = req_data;
              end
              OP_READ:  resp_data_d = heap_q[w_acc_addr];
              OP_SHIFT: state_d = S_CAPTURE;
              OP_SIZE:  resp_data_d = size_q[w_acc_a];
              default:  resp_data_d = '0;
            endcase
          end
        end
      end
      S_CAPTURE: begin
        resp_data_d = heap_q[addr_of(array_q, idx_q)];
        state_d     = (idx_q == LAST_K) ? S_CLEAR : S_MOVE;
      end
      S_MOVE: begin
        // idx_q walks upward; the removed word is already latched.
        heap_d[addr_of(array_q, idx_q)] = heap_q[addr_of(array_q, idx_q + KIW'(1))];
        idx_d = idx_q + KIW'(1);
        if (idx_q == PEN_K) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        heap_d[addr_of(array_q, LAST_K)] = '0;
        if (size_q[array_q] != '0) size_d[array_q] = size_q[array_q] - W'(1);
        state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (reset) heap_d = heap_q;
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP);
    resp_data  = (state_q == S_RESP) ? resp_data_q : '0;
    resp_error = (state_q == S_RESP) & err_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_array_shift_down.sv
// ============================================================================
// Module  : tb_array_shift_down
// Brief   : Self-checking bench for array_shift_down (tables, corner
//           sequences and randomized traffic against a queue-based model).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_array_shift_down;

  localparam int W     = 12;
  localparam int NAREA = 4;
  localparam int NARR  = 20;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [1:0]   req_op = 2'd0;
  logic [W-1:0] req_array = '0;
  logic [W-1:0] req_index = '0;
  logic [W-1:0] req_data = '0;
  logic         resp_valid;
  logic [W-1:0] resp_data;
  logic         resp_error;

  int nvec = 0;
  int nmis = 0;

  int mheap [NARR][NAREA];
  int msize [NARR];

  typedef struct {
    int op; int a; int k; int d;
    int ed; int ee; int el;
  } vec_t;
  vec_t tbl[$];

  array_shift_down #(.MemoryElementWidth(W), .NArea(NAREA), .NArrays(NARR)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_array (req_array),
    .req_index (req_index),
    .req_data  (req_data),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .resp_error(resp_error)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int op, int a, int k, int d, int ed, int ee, int el);
    vec_t v;
    v.op = op; v.a = a; v.k = k; v.d = d; v.ed = ed; v.ee = ee; v.el = el;
    return v;
  endfunction

  // Reference behaviour: array words kept as a queue for the removal.
  task automatic model_exec(input int op, input int a, input int k, input int d,
                            output int ed, output int ee, output int el);
    int q[$];
    ed = 0; ee = 0; el = 1;
    if (a >= NARR || (op != 3 && k >= NAREA)) begin
      ee = 1;
      return;
    end
    case (op)
      0: begin
        mheap[a][k] = d;
        if (k + 1 > msize[a]) msize[a] = k + 1;
        ed = d;
      end
      1: ed = mheap[a][k];
      2: begin
        for (int i = 0; i < NAREA; i++) q.push_back(mheap[a][i]);
        ed = q[k];
        q.delete(k);
        q.push_back(0);
        for (int i = 0; i < NAREA; i++) mheap[a][i] = q[i];
        if (msize[a] > 0) msize[a] = msize[a] - 1;
        el = NAREA - k + 2;
      end
      default: ed = msize[a];
    endcase
  endtask

  // Issue one request from a negedge in IDLE; returns at a negedge.
  task automatic xact(input int op, input int a, input int k, input int d,
                      output int rd, output int re, output int lat, output bit ok);
    ok = 1'b1; rd = 0; re = 0; lat = 0;
    req_valid = 1'b1;
    req_op    = 2'(op);
    req_array = W'(a);
    req_index = W'(k);
    req_data  = W'(d);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    req_op    = 2'($urandom_range(0, 3));
    req_array = W'($urandom_range(0, 4095));
    req_index = W'($urandom_range(0, 4095));
    req_data  = W'($urandom_range(0, 4095));
    lat = 1;
    while (!resp_valid && lat < NAREA + 10) begin
      @(negedge clock);
      lat++;
    end
    if (!resp_valid) begin
      ok = 1'b0;
      return;
    end
    rd = int'(resp_data);
    re = int'(resp_error);
    @(negedge clock);
    chk("pulse_end_valid", 32'(resp_valid), 32'd0);
    chk("pulse_end_data", 32'(resp_data), 32'd0);
    chk("pulse_end_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic run_model(input string tag, input int op, input int a, input int k, input int d);
    int rd, re, lat, ed, ee, el;
    bit ok;
    xact(op, a, k, d, rd, re, lat, ok);
    model_exec(op, a, k, d, ed, ee, el);
    if (!ok) begin
      nvec++; nmis++;
      $display("FAIL %s_timeout: got no response required one (op %0d a %0d k %0d)", tag, op, a, k);
    end else begin
      chk({tag, "_data"}, 32'(rd), 32'(ed));
      chk({tag, "_err"}, 32'(re), 32'(ee));
      chk({tag, "_lat"}, 32'(lat), 32'(el));
    end
  endtask

  task automatic do_reset(input bit with_req);
    reset = 1'b1;
    if (with_req) begin
      req_valid = 1'b1; req_op = 2'd0; req_array = W'(1); req_index = '0; req_data = W'(99);
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    req_valid = 1'b0;
    for (int i = 0; i < NARR; i++) msize[i] = 0;
  endtask

  initial begin
    int rd, re, lat, ed, ee, el, nresp;
    bit ok;

    do_reset(1'b0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("rst_resp_error", 32'(resp_error), 32'd0);

    for (int a = 0; a < NARR; a++)
      for (int k = 0; k < NAREA; k++)
        run_model("init_wr", 0, a, k, int'($urandom_range(1, 4095)));

    // Reset wins over a simultaneous write to (1,0).
    do_reset(1'b1);
    chk("rst2_ready", 32'(req_ready), 32'd1);
    run_model("rst_prio_rd", 1, 1, 0, 0);
    run_model("rst_size1", 3, 1, 0, 0);

    tbl.push_back(mk(0, 0, 0, 10, 10, 0, 1));
    tbl.push_back(mk(0, 0, 1, 11, 11, 0, 1));
    tbl.push_back(mk(0, 0, 2, 12, 12, 0, 1));
    tbl.push_back(mk(0, 0, 3, 13, 13, 0, 1));
    tbl.push_back(mk(2, 0, 1, 0, 11, 0, 5));
    tbl.push_back(mk(1, 0, 0, 0, 10, 0, 1));
    tbl.push_back(mk(1, 0, 1, 0, 12, 0, 1));
    tbl.push_back(mk(1, 0, 2, 0, 13, 0, 1));
    tbl.push_back(mk(1, 0, 3, 0, 0, 0, 1));
    tbl.push_back(mk(3, 0, 0, 0, 3, 0, 1));
    tbl.push_back(mk(0, 0, 1, 11, 11, 0, 1));
    tbl.push_back(mk(0, 0, 2, 12, 12, 0, 1));
    tbl.push_back(mk(0, 0, 3, 13, 13, 0, 1));
    tbl.push_back(mk(3, 0, 0, 0, 4, 0, 1));
    tbl.push_back(mk(2, 0, 3, 0, 13, 0, 3));
    tbl.push_back(mk(1, 0, 0, 0, 10, 0, 1));
    tbl.push_back(mk(1, 0, 1, 0, 11, 0, 1));
    tbl.push_back(mk(1, 0, 2, 0, 12, 0, 1));
    tbl.push_back(mk(1, 0, 3, 0, 0, 0, 1));
    tbl.push_back(mk(3, 0, 0, 0, 3, 0, 1));
    tbl.push_back(mk(1, 20, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 4, 7, 0, 1, 1));
    tbl.push_back(mk(2, 4095, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 10, 0, 1));
    tbl.push_back(mk(3, 0, 9, 0, 3, 0, 1));
    tbl.push_back(mk(2, 0, 0, 0, 10, 0, 6));
    tbl.push_back(mk(1, 0, 0, 0, 11, 0, 1));
    tbl.push_back(mk(3, 0, 0, 0, 2, 0, 1));

    foreach (tbl[i]) begin
      xact(tbl[i].op, tbl[i].a, tbl[i].k, tbl[i].d, rd, re, lat, ok);
      model_exec(tbl[i].op, tbl[i].a, tbl[i].k, tbl[i].d, ed, ee, el);
      if (!ok) begin
        nvec++; nmis++;
        $display("FAIL tbl%0d_timeout: got no response required one", i);
      end else begin
        chk($sformatf("tbl%0d_data", i), 32'(rd), 32'(tbl[i].ed));
        chk($sformatf("tbl%0d_err", i), 32'(re), 32'(tbl[i].ee));
        chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].el));
      end
    end

    // shiftDown on an array whose size is still 0 after reset.
    run_model("sd_empty", 2, 5, 0, 0);
    run_model("sd_empty_size", 3, 5, 0, 0);
    run_model("sd_empty_rd3", 1, 5, 3, 0);

    // req_valid held (with changing fields) across a long shiftDown.
    model_exec(2, 0, 0, 0, ed, ee, el);
    nresp = 0;
    req_valid = 1'b1; req_op = 2'd2; req_array = '0; req_index = '0; req_data = '0;
    @(posedge clock);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      if (c == 1) begin req_op = 2'd0; req_index = W'(3); req_data = W'(77); end
      if (resp_valid) begin
        nresp++;
        chk("hold_resp_cycle", 32'(c), 32'(el));
        chk("hold_resp_data", 32'(resp_data), 32'(ed));
        chk("hold_ready_in_resp", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
      end else if (c < el) begin
        chk("hold_busy_ready", 32'(req_ready), 32'd0);
      end else begin
        chk("hold_after_ready", 32'(req_ready), 32'd1);
      end
    end
    chk("hold_resp_count", 32'(nresp), 32'd1);
    run_model("hold_rd3", 1, 0, 3, 0);
    run_model("hold_size", 3, 0, 0, 0);

    // Reset in cycle 2 of shiftDown(0,0) aborts without a response.
    req_valid = 1'b1; req_op = 2'd2; req_array = '0; req_index = '0;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    chk("abort_c1_valid", 32'(resp_valid), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    chk("abort_c2_valid", 32'(resp_valid), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < NARR; i++) msize[i] = 0;
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_valid", 32'(resp_valid), 32'd0);
    run_model("abort_size", 3, 0, 0, 0);
    for (int k = 0; k < NAREA; k++)
      run_model("rewr0", 0, 0, k, int'($urandom_range(0, 4095)));

    for (int n = 0; n < 300; n++) begin
      int op, a, k;
      op = int'($urandom_range(0, 3));
      a  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(NARR, NARR + 3)) : int'($urandom_range(0, NARR - 1));
      k  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(NAREA, 4095)) : int'($urandom_range(0, NAREA - 1));
      run_model("rand", op, a, k, int'($urandom_range(0, 4095)));
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/array_shift_down.md
ARRAY_SHIFT_DOWN -- requirements
Module: array_shift_down

Interface
REQ-001 SHALL have parameter MemoryElementWidth, default 12, width of every heap word, size, index and data field.
REQ-002 SHALL have parameter NArea, default 4, words per array.
REQ-003 SHALL have parameter NArrays, default 20, number of arrays held.
REQ-004 SHALL have one clock and a synchronous, active-high reset, with ports as follows.
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  block idle; request accepted on clock edge where req_valid && req_ready.
REQ-009 req_op  input  2  0=write, 1=read, 2=shiftDown, 3=size query.
REQ-010 req_array  input  MemoryElementWidth  array number.
REQ-011 req_index  input  MemoryElementWidth  word index in array.
REQ-012 req_data  input  MemoryElementWidth  write data (op 0 only).
REQ-013 resp_valid  output  1  one-cycle response pulse.
REQ-014 resp_data  output  MemoryElementWidth  read value / removed value / size.
REQ-015 resp_error  output  1  request rejected, valid with resp_valid.

Function
REQ-016 SHALL hold heap of NArrays*NArea words, word (a,k) at address a*NArea+k, plus NArrays size counters.
REQ-017 SHALL register request fields at acceptance; later input changes SHALL have no effect on the operation in progress.
REQ-018 States: IDLE, CAPTURE, MOVE, CLEAR, RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 Error: req_array>=NArrays, or req_index>=NArea for ops 0-2 -> RESP in cycle 1 after acceptance, resp_error=1, resp_data=0, no heap/size change.
REQ-020 write: heap(a,k)=req_data; size(a)=max(size(a),k+1); resp_valid in cycle 1, resp_data=req_data.
REQ-021 read: resp_valid in cycle 1, resp_data=heap(a,k), no state change.
REQ-022 size query: resp_valid in cycle 1, resp_data=size(a); req_index ignored.
REQ-023 shiftDown inverse of shiftUp: removed=heap(a,k); heap(a,i)=heap(a,i+1) for i=k..NArea-2; heap(a,NArea-1)=0; size(a) decremented, saturating at 0.
REQ-024 shiftDown timing: CAPTURE cycle 1 latches removed value; MOVE one word per cycle, cycles 2..NArea-k, ascending i; CLEAR cycle NArea-k+1 zeroes top word and updates size; RESP cycle NArea-k+2.
REQ-025 k=NArea-1: zero MOVE cycles, CAPTURE->CLEAR directly, resp in cycle 3.
REQ-026 shiftDown with size(a)=0 SHALL still shift words and return removed value; size stays 0, resp_error=0.
REQ-027 RESP state SHALL last exactly one cycle, then IDLE; back-to-back acceptance possible the cycle after RESP.
REQ-028 req_valid while busy SHALL be ignored, not queued.
REQ-029 Arithmetic on sizes/indexes SHALL be unsigned MemoryElementWidth wide; addresses SHALL never exceed NArrays*NArea-1.
REQ-030 resp_data SHALL be 0 whenever resp_valid=0.

Reset
REQ-031 reset SHALL force IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_error=0, all sizes 0.
REQ-032 Heap words SHALL not be reset; reset during MOVE/CLEAR aborts; partially shifted contents unspecified, no response issued.
REQ-033 reset SHALL take priority over a simultaneous req_valid.

Verification
REQ-034 Write array 0 words 0..3 = 10,11,12,13; shiftDown(0,1) -> resp cycle 5, resp_data=11, then reads 10,12,13,0, size 3.
REQ-035 Same setup, shiftDown(0,3) -> resp cycle 3, resp_data=13, reads 10,11,12,0, size 3.
REQ-036 shiftDown on freshly reset array 5 index 0 -> resp_data=heap word, size query returns 0, resp_error=0.
REQ-037 read(20,0) and write(0,4,7) -> resp_error=1 in cycle 1, heap unchanged.
REQ-038 req_valid held during shiftDown(0,0) -> req_ready=0 until RESP, exactly one response per accepted request.
REQ-039 reset asserted in cycle 2 of shiftDown(0,0) -> no resp_valid, req_ready=1 next cycle, size query 0.
